// File: rtl/ps2_hex_entry.sv
// Hex-entry editor: decodes PS/2 scan-code set 2 bytes into hex digits and edit keys,
// maintains an editable hex buffer and a committed copy latched on Enter.
module ps2_hex_entry #(
   parameter int unsigned DIGITS          = 8,
   parameter int unsigned OVERFLOW_SHIFT  = 0,
   parameter int unsigned REPEAT_EN       = 0,
   parameter int unsigned CLEAR_ON_COMMIT = 1
) (
   input  logic                  clk100mhz,
   input  logic                  reset,
   input  logic [7:0]            scan_code,
   input  logic                  scan_valid,
   output logic [4*DIGITS-1:0]   edit_value,
   output logic [DIGITS-1:0]     edit_mask,
   output logic [4*DIGITS-1:0]   commit_value,
   output logic [DIGITS-1:0]     commit_mask,
   output logic                  commit_pulse,
   output logic                  overflow
);

   localparam int unsigned VW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CountFull = CW'(DIGITS);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StBrk    = 2'd1;
   localparam logic [1:0] StExt    = 2'd2;
   localparam logic [1:0] StExtBrk = 2'd3;

   localparam logic [7:0] CodeBreak = 8'hF0;
   localparam logic [7:0] CodeExt   = 8'hE0;
   localparam logic [7:0] CodeEnter = 8'h5A;
   localparam logic [7:0] CodeBksp  = 8'h66;
   localparam logic [7:0] CodeEsc   = 8'h76;

   // Returns {valid, nibble} for main-row and keypad hex keys.
   function automatic logic [4:0] hex_decode(input logic [7:0] code);
      case (code)
         8'h45, 8'h70: return 5'h10;
         8'h16, 8'h69: return 5'h11;
         8'h1E, 8'h72: return 5'h12;
         8'h26, 8'h7A: return 5'h13;
         8'h25, 8'h6B: return 5'h14;
         8'h2E, 8'h73: return 5'h15;
         8'h36, 8'h74: return 5'h16;
         8'h3D, 8'h6C: return 5'h17;
         8'h3E, 8'h75: return 5'h18;
         8'h46, 8'h7D: return 5'h19;
         8'h1C:        return 5'h1A;
         8'h32:        return 5'h1B;
         8'h21:        return 5'h1C;
         8'h23:        return 5'h1D;
         8'h24:        return 5'h1E;
         8'h2B:        return 5'h1F;
         default:      return 5'h00;
      endcase
   endfunction

   logic [1:0]    state_q, state_d;
   logic [VW-1:0] value_q, value_d;
   logic [DIGITS-1:0] mask_q, mask_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [VW-1:0] cvalue_q, cvalue_d;
   logic [DIGITS-1:0] cmask_q, cmask_d;
   logic          pulse_q, pulse_d;
   logic          held_valid_q, held_valid_d;
   logic          held_ext_q, held_ext_d;
   logic [7:0]    held_code_q, held_code_d;

   logic          make_valid;
   logic          make_ext;
   logic          is_repeat;
   logic [4:0]    digit;

   assign digit     = hex_decode(scan_code);
   assign is_repeat = (REPEAT_EN == 0) && held_valid_q && (held_ext_q == make_ext) &&
                      (held_code_q == scan_code);

   always_comb begin
      state_d      = state_q;
      value_d      = value_q;
      mask_d       = mask_q;
      count_d      = count_q;
      ovf_d        = ovf_q;
      cvalue_d     = cvalue_q;
      cmask_d      = cmask_q;
      pulse_d      = 1'b0;
      held_valid_d = held_valid_q;
      held_ext_d   = held_ext_q;
      held_code_d  = held_code_q;
      make_valid   = 1'b0;
      make_ext     = 1'b0;

      if (scan_valid) begin
         case (state_q)
            StIdle: begin
               if (scan_code == CodeBreak) begin
                  state_d = StBrk;
               end else if (scan_code == CodeExt) begin
                  state_d = StExt;
               end else begin
                  make_valid = 1'b1;
               end
            end
            StBrk: begin
               state_d = StIdle;
               if (held_valid_q && !held_ext_q && (held_code_q == scan_code)) begin
                  held_valid_d = 1'b0;
               end
            end
            StExt: begin
               if (scan_code == CodeBreak) begin
                  state_d = StExtBrk;
               end else begin
                  state_d = StIdle;
                  if (scan_code == CodeEnter) begin
                     make_valid = 1'b1;
                     make_ext   = 1'b1;
                  end
               end
            end
            StExtBrk: begin
               state_d = StIdle;
               if ((scan_code == CodeEnter) && held_valid_q && held_ext_q &&
                   (held_code_q == CodeEnter)) begin
                  held_valid_d = 1'b0;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (make_valid && !is_repeat) begin
         held_valid_d = 1'b1;
         held_ext_d   = make_ext;
         held_code_d  = scan_code;

         if (scan_code == CodeEnter) begin
            // Commit captures the pre-clear edit state.
            cvalue_d = value_q;
            cmask_d  = mask_q;
            pulse_d  = 1'b1;
            ovf_d    = 1'b0;
            if (CLEAR_ON_COMMIT != 0) begin
               value_d = '0;
               mask_d  = '0;
               count_d = '0;
            end
         end else if (scan_code == CodeBksp) begin
            if (count_q != '0) begin
               value_d = value_q >> 4;
               mask_d  = mask_q >> 1;
               count_d = count_q - CW'(1);
            end
         end else if (scan_code == CodeEsc) begin
            value_d = '0;
            mask_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
         end else if (digit[4]) begin
            if (count_q < CountFull) begin
               value_d = (value_q << 4) | VW'(digit[3:0]);
               mask_d  = (mask_q << 1) | DIGITS'(1);
               count_d = count_q + CW'(1);
            end else if (OVERFLOW_SHIFT != 0) begin
               value_d = (value_q << 4) | VW'(digit[3:0]);
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         state_q      <= StIdle;
         value_q      <= '0;
         mask_q       <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         cvalue_q     <= '0;
         cmask_q      <= '0;
         pulse_q      <= 1'b0;
         held_valid_q <= 1'b0;
         held_ext_q   <= 1'b0;
         held_code_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         value_q      <= value_d;
         mask_q       <= mask_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         cvalue_q     <= cvalue_d;
         cmask_q      <= cmask_d;
         pulse_q      <= pulse_d;
         held_valid_q <= held_valid_d;
         held_ext_q   <= held_ext_d;
         held_code_q  <= held_code_d;
      end
   end

   assign edit_value   = value_q;
   assign edit_mask    = mask_q;
   assign commit_value = cvalue_q;
   assign commit_mask  = cmask_q;
   assign commit_pulse = pulse_q;
   assign overflow     = ovf_q;

endmodule
